// File: rtl/zap_wb_ram_responder.sv
// rtl/zap_wb_ram_responder.sv - Wishbone B3 responder with word-addressed backing RAM
//
// Purpose: serves classic single cycles and incrementing linear bursts from an
// on-chip RAM of DEPTH 32-bit words, inserting WAIT_STATES cycles before the
// first beat of each transaction. Beats whose word index is >= DEPTH are
// answered with ERR+ACK, return zero data, never write, and end the burst.
//
// Ports:
//   i_clk      - clock, rising edge
//   i_reset    - synchronous active-high reset
//   i_wb_cyc   - bus cycle valid
//   i_wb_stb   - strobe
//   i_wb_wen   - 1 = write, 0 = read
//   i_wb_sel   - byte enables, bit n covers dat[8n+7:8n]
//   i_wb_adr   - byte address, bits [1:0] ignored
//   i_wb_dat   - write data
//   i_wb_cti   - 000 classic, 010 incrementing burst, 111 end of burst
//   o_wb_ack   - registered beat acknowledge
//   o_wb_err   - error, only high together with o_wb_ack
//   o_wb_dat   - registered read data, valid while o_wb_ack is high

module zap_wb_ram_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_wen,
  input  logic [3:0]  i_wb_sel,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [2:0]  i_wb_cti,
  output logic        o_wb_ack,
  output logic        o_wb_err,
  output logic [31:0] o_wb_dat
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [3:0]  WS = WAIT_STATES[3:0];

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [31:0] adr_q, adr_d;   // latched request address, then current beat address
  logic        wen_q, wen_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] dat_q, dat_d;   // first-beat write data latched with the request
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] rdat_q, rdat_d;

  logic [31:0] mem [DEPTH];

  // Beat issued on the coming edge (the edge that enters RESP).
  logic          beat_go;
  logic [31:0]   beat_adr;
  logic          beat_wen;
  logic [3:0]    beat_sel;
  logic [31:0]   beat_wdat;
  logic          beat_in_range;
  logic [AW-1:0] beat_idx;
  logic          req;
  logic          mem_we;

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    adr_d     = adr_q;
    wen_d     = wen_q;
    sel_d     = sel_q;
    dat_d     = dat_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    rdat_d    = rdat_q;
    beat_go   = 1'b0;
    beat_adr  = adr_q;
    beat_wen  = wen_q;
    beat_sel  = sel_q;
    beat_wdat = dat_q;
    req       = i_wb_cyc & i_wb_stb;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          adr_d = i_wb_adr;
          wen_d = i_wb_wen;
          sel_d = i_wb_sel;
          dat_d = i_wb_dat;
          if (WAIT_STATES == 0) begin
            // No wait: the request edge is also the first-beat edge.
            beat_go   = 1'b1;
            beat_adr  = i_wb_adr;
            beat_wen  = i_wb_wen;
            beat_sel  = i_wb_sel;
            beat_wdat = i_wb_dat;
          end else begin
            wcnt_d  = WS;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!i_wb_cyc) begin
          wcnt_d  = 4'd0;
          state_d = S_IDLE;
        end else if (wcnt_q == 4'd1) begin
          wcnt_d  = 4'd0;
          beat_go = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      S_RESP: begin
        // Next burst beat: master still requesting incrementing burst and
        // the beat being acknowledged now did not fail.
        if (req && (i_wb_cti == 3'b010) && !err_q) begin
          beat_go   = 1'b1;
          beat_adr  = adr_q + 32'd4;
          beat_wdat = i_wb_dat;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    beat_in_range = ((beat_adr >> (AW + 2)) == 32'd0);
    beat_idx      = beat_adr[AW+1:2];

    if (beat_go) begin
      state_d = S_RESP;
      adr_d   = beat_adr;
      ack_d   = 1'b1;
      if (beat_in_range) begin
        rdat_d = mem[beat_idx];
      end else begin
        err_d  = 1'b1;
        rdat_d = 32'd0;
      end
    end

    mem_we = beat_go & beat_wen & beat_in_range;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      wcnt_q  <= 4'd0;
      adr_q   <= 32'd0;
      wen_q   <= 1'b0;
      sel_q   <= 4'd0;
      dat_q   <= 32'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      adr_q   <= adr_d;
      wen_q   <= wen_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
    end
  end

  // RAM is never cleared; reset only suppresses a beat that has not yet committed.
  always_ff @(posedge i_clk) begin
    if (!i_reset && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (beat_sel[b]) begin
          mem[beat_idx][8*b +: 8] <= beat_wdat[8*b +: 8];
        end
      end
    end
  end

  assign o_wb_ack = ack_q;
  assign o_wb_err = err_q;
  assign o_wb_dat = rdat_q;

endmodule

// File: doc/zap_wb_ram_responder.md
# zap_wb_ram_responder

Wishbone B3 responder (slave) with a word-addressed backing RAM. It sits on the far end of the CPU-side Wishbone bus driven by the cache/TLB/tag-RAM master mux. It serves classic single cycles and incrementing linear bursts (registered-feedback CTI). Out-of-range accesses are signalled with ERR+ACK. It is used as the memory model behind the cache subsystem and as a synthesizable on-chip RAM.

## Interface
Parameters:
- DEPTH, 1024: RAM size in 32-bit words; power of two, ≥ 4.
- WAIT_STATES, 0: extra cycles inserted before the first beat of every transaction; range 0..15.

Ports (one clock; reset is synchronous and active-high):
- i_clk  in  1  clock; all logic on rising edge.
- i_reset  in  1  synchronous active-high reset.
- i_wb_cyc  in  1  bus cycle valid.
- i_wb_stb  in  1  strobe.
- i_wb_wen  in  1  1 = write, 0 = read.
- i_wb_sel  in  4  byte enables; bit n covers dat[8n+7:8n].
- i_wb_adr  in  32  byte address; bits [1:0] ignored.
- i_wb_dat  in  32  write data.
- i_wb_cti  in  3  000 classic, 010 incrementing burst, 111 end of burst; other codes are treated as 000.
- o_wb_ack  out  1  beat acknowledge, registered.
- o_wb_err  out  1  error; only ever high together with o_wb_ack.
- o_wb_dat  out  32  read data, registered, valid while o_wb_ack is high.

## Operation
- Request = i_wb_cyc & i_wb_stb. Word index = adr[31:2]. A beat is out of range when the word index ≥ DEPTH.
- States:
  - IDLE: o_wb_ack = 0. On a request, latch the address, wen, sel and dat. If WAIT_STATES = 0 go to RESP, else load wcnt = WAIT_STATES and go to WAIT.
  - WAIT: decrement wcnt each cycle. When wcnt reaches 1, go to RESP. If cyc drops, go to IDLE with no ack.
  - RESP: o_wb_ack = 1 for exactly this cycle. The beat address is the latched address for the first beat, or the previous beat address + 4 for burst beats.
- Leaving RESP:
  - Go to RESP again (next burst beat, zero wait) only if, in this ack cycle, cyc & stb are high, cti = 010, and this beat was not an error.
  - Otherwise go to IDLE. This covers classic transactions, cti = 111, an error beat, stb low, and cyc low.
- Read: o_wb_dat = mem[beat word], registered on the edge that enters RESP.
- Write: on the edge that enters RESP, each byte with sel set is written from i_wb_dat.
  - First beat: uses the latched dat.
  - Burst beats: use i_wb_dat sampled on that edge; the master advances its data on ack.
- Out-of-range beat: o_wb_ack = 1, o_wb_err = 1, o_wb_dat = 0, no RAM write. The burst is terminated.
- RAM contents are not cleared by reset. Simulation initial contents are X.

## Timing
- Reset values: o_wb_ack = 0, o_wb_err = 0, o_wb_dat = 0, state = IDLE, wcnt = 0.
- Reset asserted mid-transaction forces these values on the next edge. A write already committed stays committed, and no further beats occur.
- First-beat latency: a request sampled on edge E gives ack in the cycle after edge E+WAIT_STATES, i.e. cycle 1+WAIT_STATES relative to the request cycle.
- Classic throughput: one beat per 2+WAIT_STATES cycles. There is always one ack-low cycle between classic transactions, even with stb held high. That cycle is treated as a new request, never as a double ack.
- Burst throughput: first beat at 1+WAIT_STATES, then one beat per cycle until cti = 111 is seen in an ack cycle.
- Burst address increment is linear 32-bit. There is no wrap; crossing DEPTH produces an err beat.
- err without ack never occurs.
- o_wb_dat holds its value outside ack cycles and is never updated on err beats except to 0.

## Test plan
- Reset then idle: hold i_reset 3 cycles with stb high → ack/err/dat all 0 throughout and 0 in the first cycle after reset release.
- Classic write/read, WAIT_STATES = 2:
  - Write 0xDEADBEEF to 0x10 with sel = 1111; ack in cycle 3, one cycle wide.
  - Then read 0x10 with sel = 0011 write of 0x0000CAFE → read returns 0xDEADCAFE.
- Burst read, WAIT_STATES = 0, mem[4..7] = 0x100..0x103:
  - Address 0x10; cti 010,010,010,111 advanced on ack → acks in 4 consecutive cycles, data 0x100, 0x101, 0x102, 0x103, then ack 0.
- Out of range, DEPTH = 1024:
  - Classic read at 0x1000 → ack = 1, err = 1, dat = 0 in the same cycle.
  - Burst starting at 0xFF8 → beats 0xFF8 and 0xFFC ok, third beat err, then no further ack despite stb high.
- Abort: drop cyc during WAIT (WAIT_STATES = 3) → no ack; RAM unchanged for the pending write.
- Reset asserted on the second beat of a write burst → first beat written, second beat not written, ack = 0 on the next cycle.
